fp_normalize_round: RTL and testbench

Post-add normalization and rounding stage placed directly downstream of `floatingPointAdder`. It consumes the adder's raw result (sign, exponent, unnormalized 25-bit fraction with carry and hidden bit) through a valid/ready handshake. It normalizes iteratively: one right shift with round-to-nearest-even on carry-out, or one left shift per cycle on cancellation. It then emits a packed IEEE-754 single-precision word with overflow and underflow flags.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_rne_rshift.sv | 20 ++
 rtl/fp_normalize_round.sv | 143 ++++++++++++++
 tb/tb_fp_normalize_round.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the adder datapath and its normalizer.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      NORM,
      ROUND,
      OUT
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp_word_t;

endpackage

// File: rtl/fp_rne_rshift.sv
// Combinational right shift by one with round-to-nearest-even (sticky taken as 0).
module fp_rne_rshift #(
   parameter int W = 25
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] y,
   output logic         carry
);

   logic guard;
   logic new_lsb;

   assign guard   = a[0];
   assign new_lsb = a[1];

   // A tie rounds up only when that makes the kept LSB even.
   assign y     = {1'b0, a[W-1:1]} + W'(guard & new_lsb);
   assign carry = y[W-1];

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalizer: iterative left shift on cancellation, RNE right shift on carry,
// packed single-precision output with overflow/underflow flags over a valid/ready pair.
module fp_normalize_round
   import fp_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [FRAC_W+1:0]       in_frac,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   out_result,
   output logic                    out_overflow,
   output logic                    out_underflow
);

   localparam int FW = FRAC_W + 2;
   localparam int EW = EXP_W + 1;
   localparam logic [EW-1:0] EMAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EW-1:0] EONE = EW'(1);

   state_t        state;
   logic          s;
   logic [EW-1:0] e;
   logic [FW-1:0] f;

   logic [FW-1:0] f_shl;
   logic [EW-1:0] e_dec;
   logic [FW-1:0] r1_y;
   logic          r1_carry;
   logic [FW-1:0] f_rnd;
   logic [EW-1:0] e_rnd;

   assign in_ready = (state == IDLE);

   assign f_shl = f << 1;
   assign e_dec = e - EONE;

   fp_rne_rshift #(.W(FW)) u_rne (
      .a     (f),
      .y     (r1_y),
      .carry (r1_carry)
   );

   // A re-carry can only yield 1.000..0, so the second shift needs no rounding.
   assign f_rnd = r1_carry ? (r1_y >> 1) : r1_y;
   assign e_rnd = e + EONE + EW'(r1_carry);

   always_ff @(posedge clk) begin
      // NOTE: all state here is sequential, so only non-blocking assignments are used.
      if (reset) begin
         state         <= IDLE;
         s             <= 1'b0;
         e             <= '0;
         f             <= '0;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s     <= in_sign;
                  e     <= {1'b0, in_exp};
                  f     <= in_frac;
                  state <= CHECK;
               end
            end

            CHECK: begin
               out_overflow  <= 1'b0;
               out_underflow <= 1'b0;
               if (e == EMAX) begin
                  out_result <= {s, {EXP_W{1'b1}}, f[FRAC_W-1:0]};
                  out_valid  <= 1'b1;
                  state      <= OUT;
               end else if (f == '0) begin
                  out_result <= '0;
                  out_valid  <= 1'b1;
                  state      <= OUT;
               end else if (f[FW-1]) begin
                  state <= ROUND;
               end else if (f[FW-2]) begin
                  out_result <= {s, e[EXP_W-1:0], f[FRAC_W-1:0]};
                  out_valid  <= 1'b1;
                  state      <= OUT;
               end else if (e <= EONE) begin
                  out_result    <= {s, {(EXP_W+FRAC_W){1'b0}}};
                  out_underflow <= 1'b1;
                  out_valid     <= 1'b1;
                  state         <= OUT;
               end else begin
                  state <= NORM;
               end
            end

            NORM: begin
               e <= e_dec;
               f <= f_shl;
               if (f_shl[FW-2]) begin
                  out_result <= {s, e_dec[EXP_W-1:0], f_shl[FRAC_W-1:0]};
                  out_valid  <= 1'b1;
                  state      <= OUT;
               end else if (e_dec == EONE) begin
                  // Exponent exhausted before the hidden bit surfaced: flush, no denormals.
                  out_result    <= {s, {(EXP_W+FRAC_W){1'b0}}};
                  out_underflow <= 1'b1;
                  out_valid     <= 1'b1;
                  state         <= OUT;
               end
            end

            ROUND: begin
               if (e_rnd >= EMAX) begin
                  out_result   <= {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                  out_overflow <= 1'b1;
               end else begin
                  out_result <= {s, e_rnd[EXP_W-1:0], f_rnd[FRAC_W-1:0]};
               end
               out_valid <= 1'b1;
               state     <= OUT;
            end

            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized and directed bench for fp_normalize_round against an arithmetic reference model.
module tb_fp_normalize_round;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [24:0] in_frac;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   fp_normalize_round dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exp        (in_exp),
      .in_frac       (in_frac),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: works on integer mantissa/exponent values, not on the FSM steps.
   task automatic model(input logic sg, input int ex_in, input int fr,
                        output logic [31:0] res, output logic ov, output logic un,
                        output int lat);
      fp_word_t w;
      int mant;
      int ex;
      int k;
      ov = 1'b0;
      un = 1'b0;
      w.sign = sg;
      if (ex_in == 255) begin
         w.exp  = 8'hFF;
         w.frac = fr[22:0];
         res    = w;
         lat    = 2;
      end else if (fr == 0) begin
         res = 32'h0;
         lat = 2;
      end else if (fr >= (1 << 24)) begin
         mant = fr / 2;
         if ((fr % 2 == 1) && (mant % 2 == 1)) mant = mant + 1;
         ex = ex_in + 1;
         if (mant >= (1 << 24)) begin
            mant = mant / 2;
            ex   = ex + 1;
         end
         if (ex >= 255) begin
            ov     = 1'b1;
            w.exp  = 8'hFF;
            w.frac = '0;
         end else begin
            w.exp  = ex[7:0];
            w.frac = mant[22:0];
         end
         res = w;
         lat = 3;
      end else begin
         mant = fr;
         ex   = ex_in;
         k    = 0;
         while (mant < (1 << 23) && !un) begin
            if (ex <= 1) un = 1'b1;
            else begin
               mant = mant * 2;
               ex   = ex - 1;
               k    = k + 1;
            end
         end
         if (un) res = {sg, 31'b0};
         else begin
            w.exp  = ex[7:0];
            w.frac = mant[22:0];
            res    = w;
         end
         lat = 2 + k;
      end
   endtask

   task automatic run_op(input string tag, input logic sg, input logic [7:0] ex,
                         input logic [24:0] fr, input int hold);
      logic [31:0] exp_res;
      logic        exp_ov;
      logic        exp_un;
      int          exp_lat;
      int          cnt;
      model(sg, int'(ex), int'(fr), exp_res, exp_ov, exp_un, exp_lat);
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_sign  = sg;
      in_exp   = ex;
      in_frac  = fr;
      @(negedge clk);
      in_valid = 1'b0;
      in_sign  = $urandom_range(0, 1);
      in_exp   = 8'($urandom);
      in_frac  = 25'($urandom);
      cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
      check({tag, ".result"}, out_result, exp_res);
      check({tag, ".overflow"}, 32'(out_overflow), 32'(exp_ov));
      check({tag, ".underflow"}, 32'(out_underflow), 32'(exp_un));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_result"}, out_result, exp_res);
         check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        sg;
      logic [7:0]  ex;
      logic [24:0] fr;
      int          mode;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_frac   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.out_result", out_result, 32'd0);
      check("reset.overflow", 32'(out_overflow), 32'd0);
      check("reset.underflow", 32'(out_underflow), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("add_4p5_2p25", 1'b0, 8'h81, 25'h0D80000, 5);
      run_op("sub_pos",      1'b0, 8'h81, 25'h0480000, 1);
      run_op("sub_neg",      1'b1, 8'h81, 25'h0480000, 0);
      run_op("carry",        1'b0, 8'h81, 25'h1200000, 0);
      run_op("tie_recarry",  1'b0, 8'h80, 25'h1FFFFFF, 0);
      run_op("tie_even",     1'b0, 8'h80, 25'h1000001, 0);
      run_op("overflow",     1'b0, 8'hFE, 25'h1000000, 2);
      run_op("zero",         1'b1, 8'h40, 25'h0000000, 0);
      run_op("underflow",    1'b0, 8'h01, 25'h0400000, 0);
      run_op("flush_norm",   1'b1, 8'h02, 25'h0200000, 0);
      run_op("norm_to_e1",   1'b0, 8'h03, 25'h0200000, 0);
      run_op("shift23",      1'b0, 8'h81, 25'h0000001, 0);
      run_op("inf_nan",      1'b1, 8'hFF, 25'h0412345, 0);

      // Reset while the operand is still being shifted left.
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'h81;
      in_frac  = 25'h0000001;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset.out_valid", 32'(out_valid), 32'd0);
      check("midreset.in_ready", 32'(in_ready), 32'd1);
      repeat (30) @(negedge clk);
      check("midreset.stay_idle", 32'(out_valid), 32'd0);

      for (int n = 0; n < 300; n++) begin
         mode = int'($urandom_range(0, 5));
         sg   = 1'($urandom);
         ex   = 8'($urandom_range(1, 254));
         fr   = 25'($urandom);
         case (mode)
            0: fr[24] = 1'b1;
            1: begin fr[24] = 1'b0; fr[23] = 1'b1; end
            2: fr = fr >> $urandom_range(2, 24);
            3: begin
               ex = 8'($urandom_range(0, 6));
               fr = fr >> $urandom_range(2, 24);
            end
            4: begin
               ex = 8'($urandom_range(250, 254));
               fr[24] = 1'b1;
            end
            default: ex = 8'hFF;
         endcase
         run_op($sformatf("rand%0d", n), sg, ex, fr, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
